// File: rtl/oq_regs_rmw_arbiter.sv
// Round-robin read-modify-write arbiter for port A of the output-queue register RAM.
// Define OQ_REGS_RMW_SATURATE_EN to clamp add/sub results and drive sat_event.
module oq_regs_rmw_arbiter #(
    parameter int unsigned REG_WIDTH           = 32,
    parameter int unsigned NUM_OUTPUT_QUEUES   = 8,
    parameter int unsigned REG_FILE_ADDR_WIDTH = $clog2(NUM_OUTPUT_QUEUES)
) (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           add_req,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] add_addr,
    input  logic [REG_WIDTH-1:0]           add_amt,
    output logic                           add_ack,

    input  logic                           sub_req,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] sub_addr,
    input  logic [REG_WIDTH-1:0]           sub_amt,
    output logic                           sub_ack,

    input  logic                           reg_req,
    input  logic                           reg_rd_wr_L,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] reg_addr,
    input  logic [REG_WIDTH-1:0]           reg_wr_data,
    output logic                           reg_ack,
    output logic [REG_WIDTH-1:0]           reg_rd_data,

    output logic                           sat_event,

    output logic [REG_FILE_ADDR_WIDTH-1:0] ram_addr,
    output logic                           ram_we,
    output logic [REG_WIDTH-1:0]           ram_din,
    input  logic [REG_WIDTH-1:0]           ram_dout
);

    typedef enum logic {
        ST_IDLE,
        ST_MODIFY
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_RD,
        OP_WR
    } op_e;

    typedef enum logic [1:0] {
        SRC_ADD,
        SRC_SUB,
        SRC_REG
    } src_e;

    state_e                         state_q;
    op_e                            op_q;
    src_e                           last_q;
    logic [REG_FILE_ADDR_WIDTH-1:0] addr_q;
    logic [REG_WIDTH-1:0]           data_q;
    logic [REG_WIDTH-1:0]           rd_data_q;

    logic                           grant_valid;
    src_e                           grant_src;
    op_e                            win_op;
    logic [REG_FILE_ADDR_WIDTH-1:0] win_addr;
    logic [REG_WIDTH-1:0]           win_data;

    logic [REG_WIDTH:0]             sum_ext;
    logic [REG_WIDTH:0]             diff_ext;
    logic [REG_WIDTH-1:0]           add_res;
    logic [REG_WIDTH-1:0]           sub_res;
    logic                           clamp;
    logic [REG_WIDTH-1:0]           modify_data;
    logic                           active;

    // Search order starts just after the previous winner: add -> sub -> reg.
    always_comb begin
        grant_valid = add_req | sub_req | reg_req;
        grant_src   = SRC_ADD;
        case (last_q)
            SRC_ADD: grant_src = sub_req ? SRC_SUB : (reg_req ? SRC_REG : SRC_ADD);
            SRC_SUB: grant_src = reg_req ? SRC_REG : (add_req ? SRC_ADD : SRC_SUB);
            default: grant_src = add_req ? SRC_ADD : (sub_req ? SRC_SUB : SRC_REG);
        endcase
    end

    always_comb begin
        win_op   = OP_ADD;
        win_addr = add_addr;
        win_data = add_amt;
        case (grant_src)
            SRC_SUB: begin
                win_op   = OP_SUB;
                win_addr = sub_addr;
                win_data = sub_amt;
            end
            SRC_REG: begin
                win_op   = reg_rd_wr_L ? OP_RD : OP_WR;
                win_addr = reg_addr;
                win_data = reg_wr_data;
            end
            default: ;
        endcase
    end

    // The extra top bit of each result is the carry (add) or borrow (sub).
    always_comb begin
        sum_ext  = {1'b0, ram_dout} + {1'b0, data_q};
        diff_ext = {1'b0, ram_dout} - {1'b0, data_q};
`ifdef OQ_REGS_RMW_SATURATE_EN
        add_res  = sum_ext[REG_WIDTH]  ? '1 : sum_ext[REG_WIDTH-1:0];
        sub_res  = diff_ext[REG_WIDTH] ? '0 : diff_ext[REG_WIDTH-1:0];
        clamp    = ((op_q == OP_ADD) && sum_ext[REG_WIDTH]) ||
                   ((op_q == OP_SUB) && diff_ext[REG_WIDTH]);
`else
        add_res  = sum_ext[REG_WIDTH-1:0];
        sub_res  = diff_ext[REG_WIDTH-1:0];
        clamp    = 1'b0;
`endif
    end

    always_comb begin
        modify_data = '0;
        case (op_q)
            OP_ADD:  modify_data = add_res;
            OP_SUB:  modify_data = sub_res;
            OP_WR:   modify_data = data_q;
            default: modify_data = '0;
        endcase
    end

    // Reset masks the write cycle so an in-flight operation neither writes nor acks.
    assign active      = (state_q == ST_MODIFY) && !reset;
    assign ram_we      = active && (op_q != OP_RD);
    assign ram_din     = active ? modify_data : '0;
    assign ram_addr    = (state_q == ST_IDLE && grant_valid) ? win_addr : addr_q;
    assign add_ack     = active && (op_q == OP_ADD);
    assign sub_ack     = active && (op_q == OP_SUB);
    assign reg_ack     = active && ((op_q == OP_RD) || (op_q == OP_WR));
    assign sat_event   = active && clamp;
    assign reg_rd_data = rd_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            last_q    <= SRC_REG;
            addr_q    <= '0;
            data_q    <= '0;
            rd_data_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_q <= ST_MODIFY;
                        op_q    <= win_op;
                        addr_q  <= win_addr;
                        data_q  <= win_data;
                    end
                end
                ST_MODIFY: begin
                    state_q <= ST_IDLE;
                    case (op_q)
                        OP_ADD:  last_q <= SRC_ADD;
                        OP_SUB:  last_q <= SRC_SUB;
                        default: last_q <= SRC_REG;
                    endcase
                    if (op_q == OP_RD) begin
                        rd_data_q <= ram_dout;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    a_ack_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0({add_ack, sub_ack, reg_ack}));

    a_we_in_modify: assert property (@(posedge clk) disable iff (reset)
        ram_we |-> (state_q == ST_MODIFY));

endmodule

// File: doc/oq_regs_rmw_arbiter.md
# oq_regs_rmw_arbiter

Read-modify-write controller and arbiter for port A of the output-queue register-file RAM (sync read, sync write, one-cycle read latency). It shares that port between three requesters: the store side (adds to a per-queue counter), the remove side (subtracts from a per-queue counter) and the host register path (plain read/write). Every access is sequenced as a read cycle followed by a write/complete cycle. Port B of the RAM stays free for other logic.

## Interface
- REG_WIDTH, 32, width of each RAM word and counter.
- NUM_OUTPUT_QUEUES, 8, RAM depth (one word per queue).
- REG_FILE_ADDR_WIDTH, log2(NUM_OUTPUT_QUEUES), RAM address width; 3 by default.

Ports (clock and reset first):
- clk  in  1  the single clock.
- reset  in  1  synchronous, active-high.
- add_req  in  1  store-side request; held until add_ack.
- add_addr  in  REG_FILE_ADDR_WIDTH  queue to increment.
- add_amt  in  REG_WIDTH  amount to add.
- add_ack  out  1  one-cycle completion pulse.
- sub_req  in  1  remove-side request; held until sub_ack.
- sub_addr  in  REG_FILE_ADDR_WIDTH  queue to decrement.
- sub_amt  in  REG_WIDTH  amount to subtract.
- sub_ack  out  1  one-cycle completion pulse.
- reg_req  in  1  host request; held until reg_ack.
- reg_rd_wr_L  in  1  1 = read, 0 = write.
- reg_addr  in  REG_FILE_ADDR_WIDTH  host address.
- reg_wr_data  in  REG_WIDTH  host write data.
- reg_ack  out  1  one-cycle completion pulse.
- reg_rd_data  out  REG_WIDTH  host read data; registered, valid from the cycle after reg_ack until the next host read.
- sat_event  out  1  one-cycle pulse when an add or subtract result was clamped.
- ram_addr  out  REG_FILE_ADDR_WIDTH  RAM port A address.
- ram_we  out  1  RAM port A write enable.
- ram_din  out  REG_WIDTH  RAM port A write data.
- ram_dout  in  REG_WIDTH  RAM port A read data; valid one cycle after ram_addr is presented.

## Operation
- The FSM has two states: IDLE and MODIFY.
- **IDLE**
  - Sample the requests and pick a winner by round-robin. Order is add → sub → reg, starting after the last winner.
  - Latch the winner's op, address, amount and data.
  - Drive ram_addr from the winner's address with ram_we = 0, then go to MODIFY.
  - With no request: stay in IDLE, ram_addr holds its last value, ram_we = 0.
- **MODIFY**
  - ram_addr = latched address.
  - Add: ram_din = ram_dout + amt, ram_we = 1.
  - Sub: ram_din = ram_dout − amt, ram_we = 1.
  - Host write: ram_din = latched wr_data, ram_we = 1.
  - Host read: ram_we = 0; reg_rd_data ← ram_dout at the clock edge.
  - Assert exactly one ack (the winner's), update the round-robin pointer, return to IDLE.
- **Arithmetic**
  - Done at REG_WIDTH+1 bits; the carry/borrow bit is the overflow/underflow flag.
  - Clamping is controlled by the macro described under Configuration.
- **Handshake**
  - A requester keeps req and its operands stable until it sees its ack.
  - Req is only sampled in IDLE.
  - If req is still high in the cycle after ack, that is a new request.
- **Reset**
  - Any state goes to IDLE. An in-flight operation is dropped with no ack and no write.
  - Round-robin pointer is set so add has the highest priority.
  - Output reset values: add_ack/sub_ack/reg_ack = 0, sat_event = 0, ram_we = 0, ram_addr = 0, ram_din = 0, reg_rd_data = 0.

## Timing
- Every operation takes exactly 2 cycles: grant/read in cycle N, write/ack in cycle N+1. Peak throughput is one operation per 2 cycles.
- No read/write hazard can occur: the next read is issued in cycle N+2, after the write at N+1 has committed.
- If all three requesters hold req continuously, each is granted once every 6 cycles. Worst-case latency from req to ack is 6 cycles.
- sat_event is asserted in the same cycle as the matching ack.

## Configuration
- OQ_REGS_RMW_SATURATE_EN defined:
  - An add result above 2^REG_WIDTH−1 is clamped to all-ones.
  - A subtract result below 0 is clamped to 0.
  - sat_event pulses on either clamp.
- Not defined:
  - Results wrap modulo 2^REG_WIDTH.
  - sat_event is tied to 0.

## Test plan
- Reset, then add_req (addr 3, amt 5) with RAM[3] = 10 → ram_addr = 3 at N; at N+1 ram_we = 1, ram_din = 15, add_ack = 1; RAM[3] reads back as 15.
- add, sub and reg requests all raised in the same cycle after reset → acks arrive in order add, sub, reg at cycles 1, 3, 5. Held continuously, each ack repeats every 6 cycles.
- Host write 0xDEADBEEF to addr 7, then host read of addr 7 → reg_ack on both; reg_rd_data = 0xDEADBEEF; ram_we = 0 during the read.
- sub_req (amt 4) on RAM[2] = 1:
  - with SATURATE_EN → RAM[2] = 0, sat_event = 1;
  - without → RAM[2] = 0xFFFFFFFD, sat_event = 0.
- add_req (amt 2) on RAM[0] = 0xFFFFFFFF:
  - with SATURATE_EN → RAM[0] stays 0xFFFFFFFF, sat_event = 1;
  - without → RAM[0] = 1.
- reset asserted during MODIFY of an add → no ack, no write (RAM unchanged), all outputs at their reset values the next cycle, FSM back in IDLE.
